// File: rtl/alu_operand_stage.sv
// Operand-fetch stage ahead of the ALU: register file with write-back bypass,
// operand A/B selection and a one-entry valid/ready output register.
module alu_operand_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [5:0]  req_operator_i,
    input  logic [4:0]  req_rs1_addr_i,
    input  logic [4:0]  req_rs2_addr_i,
    input  logic        req_a_sel_i,
    input  logic        req_b_sel_i,
    input  logic [31:0] req_pc_i,
    input  logic [31:0] req_imm_i,
    input  logic        wb_en_i,
    input  logic [4:0]  wb_addr_i,
    input  logic [31:0] wb_data_i,
    output logic        alu_valid_o,
    input  logic        alu_ready_i,
    output logic [5:0]  operator_o,
    output logic [31:0] operand_a_o,
    output logic [31:0] operand_b_o
);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [31:0] r_regs [32];
    logic [0:0]  r_state;
    logic [5:0]  r_operator;
    logic [31:0] r_operand_a;
    logic [31:0] r_operand_b;

    logic [0:0]  w_state_next;
    logic        w_accept;
    logic        w_wb_write;
    logic        w_bypass_rs1;
    logic        w_bypass_rs2;
    logic [31:0] w_rs1_value;
    logic [31:0] w_rs2_value;
    logic [31:0] w_operand_a;
    logic [31:0] w_operand_b;

    assign alu_valid_o = (r_state == S_FULL);
    assign req_ready_o = !alu_valid_o || alu_ready_i;
    assign w_accept    = req_valid_i && req_ready_o;
    assign operator_o  = r_operator;
    assign operand_a_o = r_operand_a;
    assign operand_b_o = r_operand_b;

    assign w_wb_write   = wb_en_i && (wb_addr_i != 5'd0);
    assign w_bypass_rs1 = w_wb_write && (wb_addr_i == req_rs1_addr_i);
    assign w_bypass_rs2 = w_wb_write && (wb_addr_i == req_rs2_addr_i);

    // x0 is forced to zero on read so the array entry never matters
    always_comb begin
        w_rs1_value = r_regs[req_rs1_addr_i];
        w_rs2_value = r_regs[req_rs2_addr_i];
        if (req_rs1_addr_i == 5'd0) begin
            w_rs1_value = 32'd0;
        end else if (w_bypass_rs1) begin
            w_rs1_value = wb_data_i;
        end
        if (req_rs2_addr_i == 5'd0) begin
            w_rs2_value = 32'd0;
        end else if (w_bypass_rs2) begin
            w_rs2_value = wb_data_i;
        end
    end

    assign w_operand_a = req_a_sel_i ? req_pc_i  : w_rs1_value;
    assign w_operand_b = req_b_sel_i ? req_imm_i : w_rs2_value;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_EMPTY: if (w_accept) w_state_next = S_FULL;
            S_FULL:  if (alu_ready_i && !w_accept) w_state_next = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (w_wb_write) begin
            r_regs[wb_addr_i] <= wb_data_i;
        end
    end

    // Output register reloads only on accept, so a stall holds it bit-stable
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_EMPTY;
            r_operator  <= 6'd0;
            r_operand_a <= 32'd0;
            r_operand_b <= 32'd0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_operator  <= req_operator_i;
                r_operand_a <= w_operand_a;
                r_operand_b <= w_operand_b;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: directed requests push expected
// operations; a monitor pops and compares on each ALU-side handshake.
module tb_alu_operand_stage;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } expOp_t;

    localparam logic [5:0] OP_ADD = 6'b011000;
    localparam logic [5:0] OP_SUB = 6'b011001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic [5:0]  reqOperator = '0;
    logic [4:0]  reqRs1 = '0;
    logic [4:0]  reqRs2 = '0;
    logic        reqASel = 1'b0;
    logic        reqBSel = 1'b0;
    logic [31:0] reqPc = '0;
    logic [31:0] reqImm = '0;
    logic        wbEn = 1'b0;
    logic [4:0]  wbAddr = '0;
    logic [31:0] wbData = '0;
    logic        aluValid;
    logic        aluReady = 1'b1;
    logic [5:0]  operatorOut;
    logic [31:0] operandA;
    logic [31:0] operandB;

    expOp_t sb[$];
    logic   modelValid = 1'b0;
    int     total = 0;
    int     bad = 0;

    alu_operand_stage dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (reqValid),
        .req_ready_o    (reqReady),
        .req_operator_i (reqOperator),
        .req_rs1_addr_i (reqRs1),
        .req_rs2_addr_i (reqRs2),
        .req_a_sel_i    (reqASel),
        .req_b_sel_i    (reqBSel),
        .req_pc_i       (reqPc),
        .req_imm_i      (reqImm),
        .wb_en_i        (wbEn),
        .wb_addr_i      (wbAddr),
        .wb_data_i      (wbData),
        .alu_valid_o    (aluValid),
        .alu_ready_i    (aluReady),
        .operator_o     (operatorOut),
        .operand_a_o    (operandA),
        .operand_b_o    (operandB)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // One cycle: drive inputs after the edge, check handshake at the falling edge
    task automatic applyStimulus(input logic valid, input logic [5:0] op,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic aSel, input logic bSel,
                                 input logic [31:0] pc, input logic [31:0] imm,
                                 input logic wEn, input logic [4:0] wAddr, input logic [31:0] wData,
                                 input logic aluRdy, input logic [31:0] expA, input logic [31:0] expB);
        logic accept;
        expOp_t e;
        @(posedge clk);
        #1;
        reqValid = valid; reqOperator = op; reqRs1 = rs1; reqRs2 = rs2;
        reqASel = aSel; reqBSel = bSel; reqPc = pc; reqImm = imm;
        wbEn = wEn; wbAddr = wAddr; wbData = wData; aluReady = aluRdy;
        @(negedge clk);
        checkOutput("req_ready", 32'(reqReady), 32'(!modelValid || aluRdy));
        checkOutput("alu_valid", 32'(aluValid), 32'(modelValid));
        if (modelValid && !aluRdy && sb.size() > 0) begin
            checkOutput("held_op", 32'(operatorOut), 32'(sb[$].op));
            checkOutput("held_a", operandA, sb[$].a);
            checkOutput("held_b", operandB, sb[$].b);
        end
        accept = valid && (!modelValid || aluRdy);
        if (accept) begin
            e.op = op; e.a = expA; e.b = expB;
            sb.push_back(e);
            modelValid = 1'b1;
        end else if (aluRdy) begin
            modelValid = 1'b0;
        end
    endtask

    task automatic doReset(input int cycles, input logic aluRdy,
                           input logic wEn, input logic [4:0] wAddr, input logic [31:0] wData);
        @(posedge clk);
        #1;
        rst = 1'b1; reqValid = 1'b0; aluReady = aluRdy;
        wbEn = wEn; wbAddr = wAddr; wbData = wData;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0; wbEn = 1'b0;
        modelValid = 1'b0;
        sb.delete();
        checkOutput("rst_valid", 32'(aluValid), 32'd0);
        checkOutput("rst_op", 32'(operatorOut), 32'd0);
        checkOutput("rst_a", operandA, 32'd0);
        checkOutput("rst_b", operandB, 32'd0);
        checkOutput("rst_ready", 32'(reqReady), 32'd1);
    endtask

    // Monitor: every ALU-side handshake consumes the oldest expected operation
    initial begin
        expOp_t e;
        forever begin
            @(negedge clk);
            if (aluValid === 1'b1 && aluReady === 1'b1) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_op", 32'(aluValid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("sb_op", 32'(operatorOut), 32'(e.op));
                    checkOutput("sb_a", operandA, e.a);
                    checkOutput("sb_b", operandB, e.b);
                end
            end
        end
    end

    initial begin
        doReset(2, 1'b1, 1'b0, 5'd0, 32'd0);

        // Write x5, then read it through the array
        applyStimulus(0, 6'd0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h10, 1, 0, 0);
        applyStimulus(1, OP_ADD, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h10, 32'h0);
        // Bypass on both sources; writes to x0 neither store nor bypass
        applyStimulus(1, OP_ADD, 7, 7, 0, 0, 0, 0, 1, 7, 32'hDEADBEEF, 1, 32'hDEADBEEF, 32'hDEADBEEF);
        applyStimulus(1, OP_ADD, 0, 0, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 1, 32'h0, 32'h0);
        // PC/immediate select, while x3=1 is written
        applyStimulus(1, OP_SUB, 0, 0, 1, 1, 32'h1000, 32'hFFFFFFFC, 1, 3, 32'h1, 1, 32'h1000, 32'hFFFFFFFC);
        applyStimulus(1, OP_ADD, 3, 5, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1, 32'h10);
        // Stall three cycles with a pending request; x3 is rewritten to 2 meanwhile
        applyStimulus(1, OP_ADD, 3, 7, 0, 0, 0, 0, 1, 3, 32'h2, 0, 32'h2, 32'hDEADBEEF);
        applyStimulus(1, OP_ADD, 3, 7, 0, 0, 0, 0, 0, 0, 0, 0, 32'h2, 32'hDEADBEEF);
        applyStimulus(1, OP_ADD, 3, 7, 0, 0, 0, 0, 0, 0, 0, 0, 32'h2, 32'hDEADBEEF);
        applyStimulus(1, OP_ADD, 3, 7, 0, 0, 0, 0, 0, 0, 0, 1, 32'h2, 32'hDEADBEEF);
        // Back-to-back stream of eight
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 6'(i), 0, 0, 1, 1, 32'(i * 4), 32'(100 + i), 0, 0, 0, 1,
                          32'(i * 4), 32'(100 + i));
        end
        applyStimulus(0, 6'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // Reset while full and stalled; a same-cycle write-back must be lost
        applyStimulus(1, OP_ADD, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h10, 32'h0);
        applyStimulus(0, 6'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        doReset(1, 1'b0, 1'b1, 9, 32'h55);
        applyStimulus(1, OP_ADD, 5, 9, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0);
        applyStimulus(1, OP_SUB, 7, 3, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0);
        applyStimulus(0, 6'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 6'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Operand-fetch stage directly upstream of the RISC-V ALU. It holds the 32×32 integer register file, reads rs1/rs2 with write-back bypass, selects operand A (rs1 or PC) and operand B (rs2 or immediate), and registers operator plus operands into a one-entry output stage. That stage drives the ALU's operator/operand inputs under a valid/ready handshake. Write-back from the downstream writeback logic enters through a dedicated write port.

## Interface
- Parameters: none. Register file is fixed at 32 entries × 32 bits; the operator field is fixed at 6 bits, matching the ALU operator encoding.
- clk_i  in  1  single clock, all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- req_valid_i  in  1  request from decode is valid
- req_ready_o  out  1  stage can accept a request this cycle
- req_operator_i  in  6  ALU operator code, passed through unmodified
- req_rs1_addr_i  in  5  source register 1 index
- req_rs2_addr_i  in  5  source register 2 index
- req_a_sel_i  in  1  0: A = rs1 value; 1: A = req_pc_i
- req_b_sel_i  in  1  0: B = rs2 value; 1: B = req_imm_i
- req_pc_i  in  32  instruction address
- req_imm_i  in  32  sign-extended immediate (already extended upstream)
- wb_en_i  in  1  register-file write enable
- wb_addr_i  in  5  write index
- wb_data_i  in  32  write data
- alu_valid_o  out  1  operator_o/operand_*_o hold a valid operation
- alu_ready_i  in  1  ALU side consumes the operation this cycle
- operator_o  out  6  registered operator
- operand_a_o  out  32  registered operand A
- operand_b_o  out  32  registered operand B

## Operation
- Register file: 32 × 32-bit.
  - x0 always reads 0; writes to x0 are discarded.
  - Write on each rising edge with wb_en_i=1 and wb_addr_i≠0. Writes happen regardless of handshake state, including while the stage is stalled.
- Read: combinational, in the accept cycle.
- Bypass: if wb_en_i=1, wb_addr_i equals the source index, and the index is ≠0, the source value is wb_data_i, not the stored value. Applies to rs1 and rs2 independently; both may bypass at once.
- Operand select:
  - A = req_a_sel_i ? req_pc_i : rs1_value
  - B = req_b_sel_i ? req_imm_i : rs2_value
  - No width change; no arithmetic in this block.
- Handshake:
  - req_ready_o = !alu_valid_o || alu_ready_i (combinational).
  - Accept = req_valid_i && req_ready_o.
- State machine (encoded by alu_valid_o):
  - EMPTY (alu_valid_o=0): accept → FULL, outputs loaded. No accept → stay EMPTY.
  - FULL (alu_valid_o=1):
    - alu_ready_i=0 → stay FULL; outputs held bit-stable.
    - alu_ready_i=1 and accept → stay FULL; outputs reloaded with the new request (back-to-back, full throughput).
    - alu_ready_i=1 and no accept → EMPTY.
- Captured operands are snapshots. A later write to a source register does not update an operation already held in the output stage. Upstream hazard control owns this case.
- Reset: clears all 32 registers to 0 and sets alu_valid_o=0, operator_o=0, operand_a_o=0, operand_b_o=0. Reset has priority over accept and over write-back in the same cycle.

## Timing
- Latency: request accepted at edge N is presented on the outputs with alu_valid_o=1 after edge N. Sustained throughput is one operation per cycle.
- Write-back at edge N is visible through the array from cycle N+1. In the same cycle it is visible through the bypass.
- req_ready_o has a combinational path from alu_ready_i. There is no combinational path from req_valid_i to req_ready_o.
- Reset mid-operation: a held, unconsumed operation is dropped; there is no output on the cycle after reset.
- Outputs are don't-care while alu_valid_o=0, but they retain their last value; they are not cleared.

## Test plan
- Reset then write: assert rst_i for 2 cycles; all outputs 0 and req_ready_o=1. Write x5=0x0000_0010, then request ADD rs1=5, rs2=0, b_sel=0 → next cycle alu_valid_o=1, operator_o=6'b011000, A=0x10, B=0.
- Bypass: in one cycle, wb x7=0xDEAD_BEEF and request rs1=7, rs2=7 → A=B=0xDEAD_BEEF. Same with wb_addr_i=0 and wb_data_i=0xFFFF_FFFF, rs1=0 → A=0.
- Operand select: a_sel=1, pc=0x0000_1000, b_sel=1, imm=0xFFFF_FFFC, operator SUB → A=0x1000, B=0xFFFF_FFFC, operator_o=6'b011001.
- Stall and back-to-back:
  - Hold alu_ready_i=0 for 3 cycles with a request pending → outputs unchanged, req_ready_o=0, no second capture.
  - Raise alu_ready_i with a new request → outputs update next edge with alu_valid_o staying 1.
  - Stream 8 requests with alu_ready_i=1 → 8 consecutive valid cycles, in order.
- Snapshot: capture rs1=3 (x3=1) while stalled, then write x3=2 → operand_a_o stays 1. Next request reading x3 gets 2.
- Reset mid-operation: assert rst_i while FULL and stalled → next cycle alu_valid_o=0, all registers read 0, operand outputs 0.
